// File: rtl/alus_result_stage_if.sv
// Handshake and payload bundle between the ALU, the result stage and writeback.
// The result stage connects through the slave modport; the producer/consumer side uses master.
interface alus_result_stage_if #(
  parameter int unsigned N    = 24,
  parameter int unsigned RD_W = 4
);
  logic            in_valid;
  logic            in_ready;
  logic [N-1:0]    in_result;
  logic [3:0]      in_flags;
  logic [RD_W-1:0] in_rd;
  logic            in_we;
  logic            in_setflags;
  logic [3:0]      in_cond;
  logic            flush;
  logic            out_valid;
  logic            out_ready;
  logic [N-1:0]    out_result;
  logic [RD_W-1:0] out_rd;
  logic            out_we;
  logic [3:0]      flags_q;

  modport master (
    output in_valid, in_result, in_flags, in_rd, in_we, in_setflags, in_cond,
           flush, out_ready,
    input  in_ready, out_valid, out_result, out_rd, out_we, flags_q
  );

  modport slave (
    input  in_valid, in_result, in_flags, in_rd, in_we, in_setflags, in_cond,
           flush, out_ready,
    output in_ready, out_valid, out_result, out_rd, out_we, flags_q
  );
endinterface

// File: rtl/alus_result_stage.sv
// ALU result stage: 2-entry skid FIFO with condition evaluation at push and
// the architectural {N,Z,C,V} flag register.
module alus_result_stage #(
  parameter int unsigned N    = 24,
  parameter int unsigned RD_W = 4
) (
  input logic                clk,
  input logic                rst,
  alus_result_stage_if.slave bus
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  typedef struct packed {
    logic [N-1:0]    result;
    logic [RD_W-1:0] rd;
    logic            we;
  } entry_t;

  state_t     state_q, state_d;
  entry_t     mem_q [2];
  logic       rd_ptr_q, wr_ptr_q;
  logic [3:0] flags_r;
  logic       push, pop, pass;

  // Condition code against the flag register as it stands before this edge.
  function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] f);
    logic n, z, c, v;
    n = f[3];
    z = f[2];
    c = f[1];
    v = f[0];
    case (cond)
      4'b0000: cond_pass = z;
      4'b0001: cond_pass = !z;
      4'b0010: cond_pass = c;
      4'b0011: cond_pass = !c;
      4'b0100: cond_pass = n;
      4'b0101: cond_pass = !n;
      4'b0110: cond_pass = v;
      4'b0111: cond_pass = !v;
      4'b1000: cond_pass = c && !z;
      4'b1001: cond_pass = !c || z;
      4'b1010: cond_pass = (n == v);
      4'b1011: cond_pass = (n != v);
      4'b1100: cond_pass = !z && (n == v);
      4'b1101: cond_pass = z || (n != v);
      default: cond_pass = 1'b1;
    endcase
  endfunction

  assign pass = cond_pass(bus.in_cond, flags_r);

  // in_ready depends only on occupancy and reset, never on out_ready.
  assign bus.in_ready   = (state_q != FULL) && !rst;
  assign bus.out_valid  = (state_q != EMPTY);
  assign bus.out_result = mem_q[rd_ptr_q].result;
  assign bus.out_rd     = mem_q[rd_ptr_q].rd;
  assign bus.out_we     = mem_q[rd_ptr_q].we;
  assign bus.flags_q    = flags_r;

  assign push = bus.in_valid && bus.in_ready;
  assign pop  = bus.out_valid && bus.out_ready;

  // Occupancy next-state; flush empties regardless of push/pop.
  always_comb begin
    state_d = state_q;
    if (bus.flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: if (push) state_d = ONE;
        ONE: begin
          if (push && !pop)      state_d = FULL;
          else if (!push && pop) state_d = EMPTY;
        end
        FULL:    if (pop) state_d = ONE;
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= EMPTY;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      flags_r  <= 4'b0000;
      mem_q    <= '{default: '0};
    end else begin
      state_q <= state_d;
      if (bus.flush) begin
        rd_ptr_q <= 1'b0;
        wr_ptr_q <= 1'b0;
      end else begin
        if (push) begin
          mem_q[wr_ptr_q] <= '{result: bus.in_result, rd: bus.in_rd, we: bus.in_we && pass};
          wr_ptr_q        <= ~wr_ptr_q;
          if (bus.in_setflags && pass) flags_r <= bus.in_flags;
        end
        if (pop) rd_ptr_q <= ~rd_ptr_q;
      end
    end
  end

endmodule

// File: tb/tb_alus_result_stage.sv
// Directed bench for alus_result_stage: streaming, backpressure, conditions,
// flag updates, flush and asynchronous reset.
module tb_alus_result_stage;
  localparam int unsigned N    = 24;
  localparam int unsigned RD_W = 4;

  logic clk;
  logic rst;
  int   checks;
  int   passes;

  alus_result_stage_if #(.N(N), .RD_W(RD_W)) bus ();

  alus_result_stage #(.N(N), .RD_W(RD_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time=%0t required<200000", $time);
    $fatal(1);
  end

  task automatic push(input logic [N-1:0] res, input logic [RD_W-1:0] rd, input logic we,
                      input logic setf, input logic [3:0] flags, input logic [3:0] cond);
    bus.in_valid    = 1'b1;
    bus.in_result   = res;
    bus.in_rd       = rd;
    bus.in_we       = we;
    bus.in_setflags = setf;
    bus.in_flags    = flags;
    bus.in_cond     = cond;
  endtask

  task automatic idle();
    bus.in_valid    = 1'b0;
    bus.in_setflags = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle();
    bus.in_result = '0; bus.in_rd = '0; bus.in_we = 1'b0;
    bus.in_flags = 4'b0; bus.in_cond = 4'b1110; bus.flush = 1'b0; bus.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({bus.out_valid, bus.in_ready, bus.out_we, bus.flags_q} !== 7'b0)
      $display("FAIL reset_ctrl: got v/rdy/we/flags=%b required 0000000",
               {bus.out_valid, bus.in_ready, bus.out_we, bus.flags_q});
    else passes++;
    checks++;
    if ({bus.out_result, bus.out_rd} !== '0)
      $display("FAIL reset_data: got result=%h rd=%h required 0", bus.out_result, bus.out_rd);
    else passes++;
    rst = 1'b0;
    #1;
    checks++;
    if (bus.in_ready !== 1'b1)
      $display("FAIL reset_release_ready: got %b required 1", bus.in_ready);
    else passes++;
  endtask

  // Four back-to-back pushes with out_ready high: 1-cycle latency, never more than one entry.
  task automatic test_stream();
    @(negedge clk);
    bus.out_ready = 1'b1;
    push(24'h000001, 4'd1, 1'b1, 1'b0, 4'b0, 4'b1110);
    for (int i = 2; i <= 5; i++) begin
      @(negedge clk);
      checks++;
      if ({bus.out_valid, bus.out_result, bus.out_we, bus.in_ready} !== {1'b1, 24'(i - 1), 1'b1, 1'b1})
        $display("FAIL stream_%0d: got v=%b res=%h we=%b rdy=%b required v=1 res=%h we=1 rdy=1",
                 i - 1, bus.out_valid, bus.out_result, bus.out_we, bus.in_ready, 24'(i - 1));
      else passes++;
      if (i <= 4) push(24'(i), 4'(i), 1'b1, 1'b0, 4'b0, 4'b1110);
      else idle();
    end
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b0)
      $display("FAIL stream_drained: got out_valid=%b required 0", bus.out_valid);
    else passes++;
  endtask

  task automatic test_backpressure();
    bus.out_ready = 1'b0;
    push(24'h000010, 4'd2, 1'b1, 1'b0, 4'b0, 4'b1110);
    @(negedge clk);
    checks++;
    if ({bus.in_ready, bus.out_valid, bus.out_result} !== {1'b1, 1'b1, 24'h000010})
      $display("FAIL bp_one: got rdy=%b v=%b res=%h required rdy=1 v=1 res=000010",
               bus.in_ready, bus.out_valid, bus.out_result);
    else passes++;
    push(24'h000011, 4'd3, 1'b1, 1'b0, 4'b0, 4'b1110);
    @(negedge clk);
    checks++;
    if (bus.in_ready !== 1'b0)
      $display("FAIL bp_full_ready: got %b required 0", bus.in_ready);
    else passes++;
    push(24'h000012, 4'd4, 1'b1, 1'b0, 4'b0, 4'b1110);
    @(negedge clk);
    checks++;
    if ({bus.in_ready, bus.out_result} !== {1'b0, 24'h000010})
      $display("FAIL bp_blocked: got rdy=%b res=%h required rdy=0 res=000010",
               bus.in_ready, bus.out_result);
    else passes++;
    bus.out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if ({bus.in_ready, bus.out_valid, bus.out_result} !== {1'b1, 1'b1, 24'h000011})
      $display("FAIL bp_drain1: got rdy=%b v=%b res=%h required rdy=1 v=1 res=000011",
               bus.in_ready, bus.out_valid, bus.out_result);
    else passes++;
    @(negedge clk);
    checks++;
    if ({bus.out_valid, bus.out_result, bus.out_rd} !== {1'b1, 24'h000012, 4'd4})
      $display("FAIL bp_third: got v=%b res=%h rd=%h required v=1 res=000012 rd=4",
               bus.out_valid, bus.out_result, bus.out_rd);
    else passes++;
    idle();
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b0)
      $display("FAIL bp_empty: got out_valid=%b required 0", bus.out_valid);
    else passes++;
  endtask

  task automatic test_flags();
    bus.out_ready = 1'b1;
    push(24'h000020, 4'd1, 1'b1, 1'b1, 4'b0100, 4'b1110);
    @(negedge clk);
    checks++;
    if ({bus.flags_q, bus.out_we} !== {4'b0100, 1'b1})
      $display("FAIL flags_set_z: got flags=%b we=%b required flags=0100 we=1", bus.flags_q, bus.out_we);
    else passes++;
    push(24'h000021, 4'd2, 1'b1, 1'b0, 4'b0, 4'b0000);
    @(negedge clk);
    checks++;
    if ({bus.out_result, bus.out_we} !== {24'h000021, 1'b1})
      $display("FAIL cond_eq: got res=%h we=%b required res=000021 we=1", bus.out_result, bus.out_we);
    else passes++;
    push(24'h000022, 4'd3, 1'b1, 1'b0, 4'b0, 4'b0001);
    @(negedge clk);
    checks++;
    if ({bus.out_valid, bus.out_result, bus.out_rd, bus.out_we} !== {1'b1, 24'h000022, 4'd3, 1'b0})
      $display("FAIL cond_ne: got v=%b res=%h rd=%h we=%b required v=1 res=000022 rd=3 we=0",
               bus.out_valid, bus.out_result, bus.out_rd, bus.out_we);
    else passes++;
    push(24'h000023, 4'd4, 1'b1, 1'b1, 4'b1111, 4'b0001);
    @(negedge clk);
    checks++;
    if ({bus.flags_q, bus.out_we, bus.out_result} !== {4'b0100, 1'b0, 24'h000023})
      $display("FAIL setflags_fail: got flags=%b we=%b res=%h required flags=0100 we=0 res=000023",
               bus.flags_q, bus.out_we, bus.out_result);
    else passes++;
    push(24'h000024, 4'd5, 1'b0, 1'b1, 4'b0010, 4'b1111);
    @(negedge clk);
    checks++;
    if (bus.flags_q !== 4'b0010)
      $display("FAIL flags_set_c: got %b required 0010", bus.flags_q);
    else passes++;
    push(24'h000025, 4'd6, 1'b1, 1'b0, 4'b0, 4'b0010);
    @(negedge clk);
    checks++;
    if (bus.out_we !== 1'b1)
      $display("FAIL cond_cs_b2b: got we=%b required 1", bus.out_we);
    else passes++;
    push(24'h000026, 4'd7, 1'b1, 1'b0, 4'b0, 4'b1100);
    @(negedge clk);
    checks++;
    if (bus.out_we !== 1'b1)
      $display("FAIL cond_gt: got we=%b required 1", bus.out_we);
    else passes++;
    push(24'h000027, 4'd8, 1'b1, 1'b0, 4'b0, 4'b1011);
    @(negedge clk);
    checks++;
    if ({bus.out_result, bus.out_we} !== {24'h000027, 1'b0})
      $display("FAIL cond_lt: got res=%h we=%b required res=000027 we=0", bus.out_result, bus.out_we);
    else passes++;
    push(24'h000028, 4'd9, 1'b1, 1'b0, 4'b0, 4'b1000);
    @(negedge clk);
    checks++;
    if (bus.out_we !== 1'b1)
      $display("FAIL cond_hi: got we=%b required 1", bus.out_we);
    else passes++;
    idle();
    @(negedge clk);
  endtask

  task automatic test_flush();
    bus.out_ready = 1'b0;
    push(24'h000030, 4'd1, 1'b1, 1'b0, 4'b0, 4'b1110);
    @(negedge clk);
    push(24'h000031, 4'd2, 1'b1, 1'b0, 4'b0, 4'b1110);
    @(negedge clk);
    push(24'h000032, 4'd3, 1'b1, 1'b1, 4'b1000, 4'b1110);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    idle();
    checks++;
    if ({bus.out_valid, bus.in_ready, bus.flags_q} !== {1'b0, 1'b1, 4'b0010})
      $display("FAIL flush_full: got v=%b rdy=%b flags=%b required v=0 rdy=1 flags=0010",
               bus.out_valid, bus.in_ready, bus.flags_q);
    else passes++;
    // Flush while one entry is being consumed and a push with a flag update is offered.
    push(24'h000040, 4'd4, 1'b1, 1'b0, 4'b0, 4'b1110);
    @(negedge clk);
    bus.out_ready = 1'b1;
    push(24'h000041, 4'd5, 1'b1, 1'b1, 4'b1001, 4'b1110);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    idle();
    checks++;
    if ({bus.out_valid, bus.flags_q} !== {1'b0, 4'b0010})
      $display("FAIL flush_drop_push: got v=%b flags=%b required v=0 flags=0010",
               bus.out_valid, bus.flags_q);
    else passes++;
    push(24'h000042, 4'd6, 1'b1, 1'b0, 4'b0, 4'b1110);
    @(negedge clk);
    idle();
    checks++;
    if ({bus.out_valid, bus.out_result, bus.out_rd} !== {1'b1, 24'h000042, 4'd6})
      $display("FAIL flush_recover: got v=%b res=%h rd=%h required v=1 res=000042 rd=6",
               bus.out_valid, bus.out_result, bus.out_rd);
    else passes++;
    @(negedge clk);
  endtask

  task automatic test_async_reset();
    bus.out_ready = 1'b0;
    push(24'h000050, 4'd1, 1'b1, 1'b0, 4'b0, 4'b1110);
    @(negedge clk);
    push(24'h000051, 4'd2, 1'b1, 1'b0, 4'b0, 4'b1110);
    @(negedge clk);
    idle();
    checks++;
    if ({bus.out_valid, bus.out_we, bus.in_ready, bus.flags_q} !== {1'b1, 1'b1, 1'b0, 4'b0010})
      $display("FAIL prereset_full: got v=%b we=%b rdy=%b flags=%b required v=1 we=1 rdy=0 flags=0010",
               bus.out_valid, bus.out_we, bus.in_ready, bus.flags_q);
    else passes++;
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({bus.out_valid, bus.out_we, bus.in_ready, bus.flags_q} !== 7'b0)
      $display("FAIL async_reset: got v=%b we=%b rdy=%b flags=%b required all 0",
               bus.out_valid, bus.out_we, bus.in_ready, bus.flags_q);
    else passes++;
    bus.out_ready = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if ({bus.in_ready, bus.out_valid} !== 2'b10)
      $display("FAIL reset_release: got rdy=%b v=%b required rdy=1 v=0", bus.in_ready, bus.out_valid);
    else passes++;
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b0)
      $display("FAIL reset_no_output: got out_valid=%b required 0", bus.out_valid);
    else passes++;
  endtask

  initial begin
    checks = 0;
    passes = 0;
    test_reset();
    test_stream();
    test_backpressure();
    test_flags();
    test_flush();
    test_async_reset();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/alus_result_stage.md
ALUS_RESULT_STAGE -- requirements
Module: alus_result_stage

Interface
REQ-001 SHALL have parameter N, default 24, ALU datapath width (matches scalar ALU).
REQ-002 SHALL have parameter RD_W, default 4, destination register index width.
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  1  ALU stage presents an instruction result.
REQ-006 SHALL have port in_ready  output  1  stage can accept this cycle.
REQ-007 SHALL have port in_result  input  N  ALU result (from scalar ALU result mux).
REQ-008 SHALL have port in_flags  input  4  ALU flags {N,Z,C,V} at bits [3:0].
REQ-009 SHALL have port in_rd  input  RD_W  destination register index.
REQ-010 SHALL have port in_we  input  1  instruction writes register file.
REQ-011 SHALL have port in_setflags  input  1  instruction updates flag register.
REQ-012 SHALL have port in_cond  input  4  condition code.
REQ-013 SHALL have port flush  input  1  discard all buffered, uncommitted entries.
REQ-014 SHALL have port out_valid  output  1  head entry valid.
REQ-015 SHALL have port out_ready  input  1  downstream (memory/writeback) consumes head.
REQ-016 SHALL have ports out_result (N), out_rd (RD_W), out_we (1)  outputs  head entry fields.
REQ-017 SHALL have port flags_q  output  4  architectural flag register {N,Z,C,V}.

Function
REQ-018 SHALL hold a 2-entry FIFO skid buffer; state EMPTY(0)/ONE(1)/FULL(2) from an entry count register.
REQ-019 in_ready SHALL equal (count != 2) and rst low; never depends combinationally on out_ready.
REQ-020 Push SHALL occur when in_valid & in_ready; pop when out_valid & out_ready; out_valid = (count != 0).
REQ-021 Latency SHALL be 1 cycle: entry pushed at edge t drives outputs after edge t when buffer was EMPTY; sustained throughput 1/cycle.
REQ-022 Simultaneous push and pop SHALL keep count unchanged and preserve FIFO order (ONE: head replaced by new entry; FULL: push impossible).
REQ-023 Condition pass SHALL be evaluated at push against flags_q before any same-cycle update: 0000 EQ Z; 0001 NE !Z; 0010 CS C; 0011 CC !C; 0100 MI N; 0101 PL !N; 0110 VS V; 0111 VC !V; 1000 HI C&!Z; 1001 LS !C|Z; 1010 GE N==V; 1011 LT N!=V; 1100 GT !Z&(N==V); 1101 LE Z|(N!=V); 1110 and 1111 AL.
REQ-024 Stored out_we SHALL be in_we & pass; failed-condition instructions still occupy an entry (keeps order), out_result/out_rd stored unchanged.
REQ-025 flags_q SHALL load in_flags at the push edge iff in_setflags & pass; back-to-back pushes see the previous push's update.
REQ-026 flush SHALL, at the next edge, set count to 0 and drop any same-cycle push, including its flag update; flags_q otherwise unchanged.
REQ-027 flush with out_ready high SHALL still count the head as consumed in that cycle (downstream sees it once).
REQ-028 Read/write pointers SHALL be 1 bit each and wrap 1->0.

Reset
REQ-029 On rst high, asynchronously: count=0, pointers=0, out_valid=0, out_result=0, out_rd=0, out_we=0, flags_q=4'b0000, in_ready=0.
REQ-030 in_ready SHALL be 1 in the first cycle after rst deasserts; reset asserted mid-operation SHALL discard all entries with no output.

Verification
REQ-031 Stream 4 pushes (results 0x000001..0x000004, cond AL, we=1), out_ready=1 -> outputs in order, one per cycle, 1-cycle latency, count never >1.
REQ-032 out_ready=0, push 3 entries -> third blocked, in_ready=0 after 2 accepted; release out_ready -> 2 entries drain in order, third then accepted.
REQ-033 Push setflags with in_flags=4'b0100 (Z), then push cond EQ we=1 -> out_we=1; then cond NE -> out_we=0, entry still emitted.
REQ-034 Push setflags cond NE while flags_q=Z set -> condition fails, flags_q stays 4'b0100, out_we=0.
REQ-035 FULL buffer, assert flush with simultaneous push -> next cycle out_valid=0, count=0, dropped push absent, flags_q unchanged.
REQ-036 Assert rst asynchronously between edges with 2 entries -> out_valid, out_we, flags_q go to 0 immediately; after release in_ready=1.
